// File: rtl/bpm_uart_tx.sv
// bpm_uart_tx: clamps a tempo value, splits it into three ASCII digits and sends "DDD\r\n" as 8N1 UART.
// A single pending slot holds the newest value that arrives while a frame is in flight.
module bpm_uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int BPM_MAX = 250
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [$clog2(BPM_MAX+1)-1:0] bpm_i,
  input  logic                         bpm_valid,
  output logic                         tx_o,
  output logic                         busy_o
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  typedef enum logic [2:0] {IDLE, CONV, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [9:0] val_q, val_d, pval_q, pval_d, in_val;
  logic [3:0] hund_q, hund_d, tens_q, tens_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d, byte_q, byte_d;
  logic pend_q, pend_d, arm_q, tx_q, tx_d, busy_q;
  logic valid_ok, bit_end;
  logic [7:0] cur_byte;
  // arm_q masks the strobe during the first cycle after reset release
  assign valid_ok = bpm_valid & arm_q;
  assign in_val = 10'(bpm_i) > 10'(BPM_MAX) ? 10'(BPM_MAX) : 10'(bpm_i);
  assign bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);
  // after CONV the remainder left in val_q is the units digit
  assign cur_byte = byte_q == 3'd0 ? {4'h3, hund_q} :
                    byte_q == 3'd1 ? {4'h3, tens_q} :
                    byte_q == 3'd2 ? {4'h3, val_q[3:0]} :
                    byte_q == 3'd3 ? 8'h0d : 8'h0a;
  always_comb begin
    state_d = state_q;
    val_d = val_q;
    hund_d = hund_q;
    tens_d = tens_q;
    bit_d = bit_q;
    byte_d = byte_q;
    cnt_d = (state_q inside {START, DATA, STOP}) && !bit_end ? cnt_q + 1'b1 : '0;
    pend_d = pend_q | (valid_ok && (state_q != IDLE));
    pval_d = valid_ok && (state_q != IDLE) ? in_val : pval_q;
    case (state_q)
      IDLE: if (valid_ok) begin
        state_d = CONV;
        val_d = in_val;
        hund_d = '0;
        tens_d = '0;
      end
      CONV: if (val_q >= 10'd100) begin
        val_d = val_q - 10'd100;
        hund_d = hund_q + 4'd1;
      end else if (val_q >= 10'd10) begin
        val_d = val_q - 10'd10;
        tens_d = tens_q + 4'd1;
      end else begin
        state_d = START;
        byte_d = '0;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (bit_end) begin
        state_d = bit_q == 3'd7 ? STOP : DATA;
        bit_d = bit_q + 3'd1;
      end
      STOP: if (bit_end) begin
        if (byte_q != 3'd4) begin
          state_d = START;
          byte_d = byte_q + 3'd1;
        end else if (pend_q | valid_ok) begin
          state_d = CONV;
          val_d = valid_ok ? in_val : pval_q;
          hund_d = '0;
          tens_d = '0;
          pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? cur_byte[bit_d] : 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      val_q <= '0;
      pval_q <= '0;
      hund_q <= '0;
      tens_q <= '0;
      cnt_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      pend_q <= 1'b0;
      arm_q <= 1'b0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q <= val_d;
      pval_q <= pval_d;
      hund_q <= hund_d;
      tens_q <= tens_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      pend_q <= pend_d;
      arm_q <= 1'b1;
      tx_q <= tx_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign tx_o = tx_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_bpm_uart_tx.sv
// tb_bpm_uart_tx: random and directed tempo strobes; a frame-level model predicts every tx_o bit and busy_o.
module tb_bpm_uart_tx;
  localparam int C = 4;
  localparam int FB = 50 * C;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [7:0] bpm_i = '0;
  logic bpm_valid = 1'b0;
  logic tx_o, busy_o;
  int n_chk = 0, n_fail = 0;
  bpm_uart_tx #(.CLKS_PER_BIT(C), .BPM_MAX(250)) dut (
    .clk_i(clk), .rst_i(rst_i), .bpm_i(bpm_i), .bpm_valid(bpm_valid), .tx_o(tx_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] fbyte(int v, int i);
    int c;
    c = v > 250 ? 250 : v;
    return i == 0 ? 8'(48 + c / 100) : i == 1 ? 8'(48 + (c / 10) % 10) : i == 2 ? 8'(48 + c % 10) :
           i == 3 ? 8'h0d : 8'h0a;
  endfunction
  function automatic logic [39:0] frame40(int v);
    return {fbyte(v, 0), fbyte(v, 1), fbyte(v, 2), fbyte(v, 3), fbyte(v, 4)};
  endfunction
  // bit k of a frame: slot 0 start, slots 1..8 data LSB first, slot 9 stop
  function automatic logic fbit(int v, int k);
    int b;
    logic [7:0] by;
    b = (k / C) % 10;
    by = fbyte(v, k / (10 * C));
    return b == 0 ? 1'b0 : b == 9 ? 1'b1 : by[b-1];
  endfunction
  task automatic chk(string nm, logic [39:0] act, logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  logic rec_v = 1'b0;
  logic [7:0] rec_b = '0;
  logic m_busy = 1'b0, m_pend = 1'b0, pinned = 1'b0;
  int m_pval = 0, m_cur = 0, phase = 0, k = 0, wcnt = 0, rst_hi = 0;
  always @(negedge clk) begin
    if (!rst_i) begin
      m_busy = 1'b0;
      m_pend = 1'b0;
      phase = 0;
      rst_hi = 0;
      chk("reset_tx", 40'(tx_o), 40'd1);
      chk("reset_busy", 40'(busy_o), 40'd0);
    end else begin
      if (!pinned) begin
        pinned = 1'b1;
        chk("pin_120", frame40(120), 40'h3132300d0a);
        chk("pin_0", frame40(0), 40'h3030300d0a);
        chk("pin_255", frame40(255), 40'h3235300d0a);
        chk("pin_90", frame40(90), 40'h3039300d0a);
        chk("pin_bits", 40'({fbit(120, 0), fbit(120, 4), fbit(120, 8), fbit(120, 36), fbit(120, 199)}), 40'b01011);
      end
      if (rst_hi >= 2 && rec_v) begin
        if (m_busy) begin
          m_pend = 1'b1;
          m_pval = rec_b;
        end else begin
          m_busy = 1'b1;
          m_cur = rec_b;
          phase = 1;
          wcnt = 0;
        end
      end
      if (phase == 2 && k == FB) begin
        if (m_pend) begin
          m_cur = m_pval;
          m_pend = 1'b0;
          phase = 1;
          wcnt = 0;
        end else begin
          phase = 0;
          m_busy = 1'b0;
        end
      end
      if (phase == 1) begin
        if (tx_o === 1'b0) begin
          phase = 2;
          k = 0;
        end else begin
          wcnt++;
          if (wcnt > 16) begin
            chk("start_latency", 40'(wcnt), 40'd16);
            phase = 0;
            m_busy = 1'b0;
            m_pend = 1'b0;
          end
        end
      end
      if (phase == 2) begin
        chk("tx_bit", 40'(tx_o), 40'(fbit(m_cur, k)));
        k++;
      end else begin
        chk("tx_idle", 40'(tx_o), 40'd1);
      end
      chk("busy", 40'(busy_o), 40'(m_busy));
      if (rst_hi < 10) rst_hi++;
    end
    rec_v = bpm_valid;
    rec_b = bpm_i;
  end
  task automatic strobe(int v);
    @(posedge clk);
    #1;
    bpm_valid = 1'b1;
    bpm_i = 8'(v);
    @(posedge clk);
    #1;
    bpm_valid = 1'b0;
  endtask
  task automatic wait_start();
    for (int i = 0; i < 40 && tx_o; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy_o; i++) @(posedge clk);
    repeat (3) @(posedge clk);
  endtask
  initial begin
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;
    bpm_valid = 1'b1;
    bpm_i = 8'd77;
    @(posedge clk);
    #1;
    bpm_valid = 1'b0;
    repeat (20) @(posedge clk);
    strobe(120);
    wait_idle();
    strobe(0);
    wait_idle();
    strobe(255);
    wait_idle();
    strobe(60);
    wait_start();
    repeat (30) @(posedge clk);
    strobe(75);
    repeat (40) @(posedge clk);
    strobe(90);
    wait_idle();
    strobe(150);
    wait_start();
    repeat (FB - 2) @(posedge clk);
    #1;
    bpm_valid = 1'b1;
    bpm_i = 8'd200;
    @(posedge clk);
    #1;
    bpm_valid = 1'b0;
    wait_idle();
    strobe(42);
    wait_start();
    repeat (52) @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    repeat (300) @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      strobe($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) begin
        repeat ($urandom_range(1, 120)) @(posedge clk);
        strobe($urandom_range(0, 255));
      end
      if ($urandom_range(0, 1) == 1) wait_idle();
      else repeat ($urandom_range(0, 250)) @(posedge clk);
    end
    wait_idle();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
